// File: rtl/rs_pkg.sv
// ---------------------------------------------------------------------------
// rs_pkg
// Shared constants and types for the RS(15,11) decoder front end.
//   RS_N / RS_K / RS_NSYN : code length, message length, number of syndromes
//   SYM_W                 : GF(16) symbol width
//   LAST_IDX              : symbol counter value of the last symbol r0
//   CTRL_CLEAR / CTRL_ACC : syndrome cell CONTROL words (feedback off / on)
//   state_e               : sequencer FSM states
// ---------------------------------------------------------------------------
package rs_pkg;

  localparam int RS_N    = 15;
  localparam int RS_K    = 11;
  localparam int RS_NSYN = 4;
  localparam int SYM_W   = 4;

  localparam logic [3:0] LAST_IDX   = 4'd14;
  localparam logic [3:0] CTRL_CLEAR = 4'b0000;
  localparam logic [3:0] CTRL_ACC   = 4'b1111;

  typedef logic [SYM_W-1:0]         sym_t;
  typedef logic [RS_NSYN*SYM_W-1:0] synd_vec_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // True when every syndrome in the packed vector is zero (no detectable error).
  function automatic logic all_zero(input synd_vec_t s);
    return (s == {(RS_NSYN*SYM_W){1'b0}});
  endfunction

endpackage

// File: rtl/syndrome_sequencer_if.sv
// ---------------------------------------------------------------------------
// syndrome_sequencer_if
// Bundles the sequencer's symbol input stream, the shared syndrome-cell bus
// and the syndrome output stream.
//   master : environment side (symbol source, cells, key-equation stage)
//   slave  : the syndrome_sequencer itself
// ---------------------------------------------------------------------------
interface syndrome_sequencer_if;
  import rs_pkg::*;

  // input symbol stream
  sym_t       IN_SYMBOL;
  logic       IN_VALID;
  logic       IN_READY;
  // shared cell bus
  sym_t       CELL_SYMBOL;
  logic [3:0] CELL_CONTROL;
  sym_t       CELL_S1;
  sym_t       CELL_S2;
  sym_t       CELL_S3;
  sym_t       CELL_S4;
  // syndrome output stream
  sym_t       SYND_S1;
  sym_t       SYND_S2;
  sym_t       SYND_S3;
  sym_t       SYND_S4;
  logic       SYND_VALID;
  logic       SYND_READY;
  logic       SYND_ZERO;
  logic       ABORT;

  modport master (
    output IN_SYMBOL, IN_VALID, CELL_S1, CELL_S2, CELL_S3, CELL_S4, SYND_READY,
    input  IN_READY, CELL_SYMBOL, CELL_CONTROL,
    input  SYND_S1, SYND_S2, SYND_S3, SYND_S4, SYND_VALID, SYND_ZERO, ABORT
  );

  modport slave (
    input  IN_SYMBOL, IN_VALID, CELL_S1, CELL_S2, CELL_S3, CELL_S4, SYND_READY,
    output IN_READY, CELL_SYMBOL, CELL_CONTROL,
    output SYND_S1, SYND_S2, SYND_S3, SYND_S4, SYND_VALID, SYND_ZERO, ABORT
  );

endinterface

// File: rtl/syndrome_sequencer.sv
// ---------------------------------------------------------------------------
// syndrome_sequencer
// Drives the four RS(15,11) syndrome cells with one received symbol per
// cycle, clears their feedback on the first symbol of each codeword and
// captures the four syndromes on the 15th symbol into a one-deep output
// register with a valid/ready handshake.
// Ports:
//   CLK           system clock, rising edge
//   RESET_GLOBAL  asynchronous active-low reset
//   bus           syndrome_sequencer_if.slave (symbol in, cell bus, synd out)
// CELL_SYMBOL, CELL_CONTROL and IN_READY are combinational; all other outputs
// are registered.
// ---------------------------------------------------------------------------
module syndrome_sequencer
  import rs_pkg::*;
(
  input logic                 CLK,
  input logic                 RESET_GLOBAL,
  syndrome_sequencer_if.slave bus
);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  synd_vec_t  synd_q, synd_d;
  logic       valid_q, valid_d;
  logic       zero_q, zero_d;
  logic       abort_q, abort_d;

  logic       in_ready_s;
  logic [3:0] ctrl_s;
  sym_t       sym_s;
  synd_vec_t  cell_s;

  // S1 occupies the least significant nibble.
  assign cell_s = {bus.CELL_S4, bus.CELL_S3, bus.CELL_S2, bus.CELL_S1};

  // Next-state, capture and cell-bus decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    synd_d     = synd_q;
    zero_d     = zero_q;
    // A pending syndrome set drains when the consumer is ready; a capture
    // below overrides this and keeps the register full.
    valid_d    = valid_q & ~bus.SYND_READY;
    abort_d    = 1'b0;
    in_ready_s = 1'b1;
    ctrl_s     = CTRL_CLEAR;
    sym_s      = '0;

    case (state_q)
      IDLE: begin
        // Only start a codeword when its result has somewhere to go.
        in_ready_s = ~valid_q | bus.SYND_READY;
        if (bus.IN_VALID && in_ready_s) begin
          sym_s   = bus.IN_SYMBOL;
          cnt_d   = 4'd1;
          state_d = RUN;
        end else begin
          sym_s   = '0;
        end
      end

      RUN: begin
        if (bus.IN_VALID) begin
          ctrl_s = CTRL_ACC;
          sym_s  = bus.IN_SYMBOL;
          if (cnt_q == LAST_IDX) begin
            // Cell outputs already include r0 combinationally this cycle.
            synd_d  = cell_s;
            zero_d  = all_zero(cell_s);
            valid_d = 1'b1;
            cnt_d   = 4'd0;
            state_d = IDLE;
          end else begin
            cnt_d   = cnt_q + 4'd1;
          end
        end else begin
          // The cells clock every cycle, so a gap corrupts the codeword.
          abort_d = 1'b1;
          ctrl_s  = CTRL_CLEAR;
          sym_s   = '0;
          cnt_d   = 4'd0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge CLK or negedge RESET_GLOBAL) begin
    if (!RESET_GLOBAL) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      synd_q  <= '0;
      valid_q <= 1'b0;
      zero_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      synd_q  <= synd_d;
      valid_q <= valid_d;
      zero_q  <= zero_d;
      abort_q <= abort_d;
    end
  end

  assign bus.IN_READY     = in_ready_s;
  assign bus.CELL_CONTROL = ctrl_s;
  assign bus.CELL_SYMBOL  = sym_s;
  assign bus.SYND_S1      = synd_q[3:0];
  assign bus.SYND_S2      = synd_q[7:4];
  assign bus.SYND_S3      = synd_q[11:8];
  assign bus.SYND_S4      = synd_q[15:12];
  assign bus.SYND_VALID   = valid_q;
  assign bus.SYND_ZERO    = zero_q;
  assign bus.ABORT        = abort_q;

endmodule
